ocm_stream_sequencer: RTL

OCM_STREAM_SEQUENCER -- requirements
Module: ocm_stream_sequencer

---
 rtl/ocm_seq_pkg.sv | 18 +
 rtl/ocm_stream_sequencer_if.sv | 41 ++++
 rtl/ocm_seq_delay.sv | 34 +++
 rtl/ocm_stream_sequencer.sv | 121 ++++++++++++
 4 files changed

// File: rtl/ocm_seq_pkg.sv
// Shared FSM state type and default parameters
// for the OCM stream sequencer.
package ocm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam int N_WORDS_DEF  = 1024;
  localparam int ADDR_W_DEF   = 17;
  localparam int DATA_W_DEF   = 8;
  localparam int RD_LAT_DEF   = 1;
  localparam int PIPE_LAT_DEF = 2;

endpackage

// File: rtl/ocm_stream_sequencer_if.sv
// OCM0 read port, datapath feed/result and OCM1 write port.
// master = sequencer side, slave = memories + datapath side.
interface ocm_stream_sequencer_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);

  logic [ADDR_W-1:0] ocm0_addr;
  logic              ocm0_chip;
  logic              ocm0_clk_enab;
  logic [DATA_W-1:0] ocm0_readdata;

  logic [DATA_W-1:0] dp_data;
  logic              dp_valid;
  logic [DATA_W-1:0] dp_result;

  logic [ADDR_W-1:0] ocm1_addr;
  logic              ocm1_chip;
  logic              ocm1_clk_enab;
  logic              ocm1_write;
  logic [DATA_W-1:0] ocm1_writedata;

  modport master (
    output ocm0_addr, ocm0_chip, ocm0_clk_enab,
    input  ocm0_readdata,
    output dp_data, dp_valid,
    input  dp_result,
    output ocm1_addr, ocm1_chip, ocm1_clk_enab,
    output ocm1_write, ocm1_writedata
  );

  modport slave (
    input  ocm0_addr, ocm0_chip, ocm0_clk_enab,
    output ocm0_readdata,
    input  dp_data, dp_valid,
    output dp_result,
    input  ocm1_addr, ocm1_chip, ocm1_clk_enab,
    input  ocm1_write, ocm1_writedata
  );

endinterface

// File: rtl/ocm_seq_delay.sv
// 1-bit strobe delay line with async clear.
// DEPTH = 0 degenerates to a plain wire.
module ocm_seq_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q_o = d_i;
  end else if (DEPTH == 1) begin : g_one
    logic sr_q;
    // single-stage delay
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr_q <= 1'b0;
      else        sr_q <= d_i;
    end
    assign q_o = sr_q;
  end else begin : g_sr
    logic [DEPTH-1:0] sr_q;
    // shift toward the MSB, oldest sample out
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sr_q <= '0;
      else        sr_q <= {sr_q[DEPTH-2:0], d_i};
    end
    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/ocm_stream_sequencer.sv
// Streams one frame OCM0 -> datapath -> OCM1 per start edge.
// Define OCM_SEQ_PERF_EN to add the cycle_count output.
module ocm_stream_sequencer
  import ocm_seq_pkg::*;
#(
  parameter int N_WORDS  = N_WORDS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_LAT   = RD_LAT_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] wr_count,
`ifdef OCM_SEQ_PERF_EN
  output logic [31:0]       cycle_count,
`endif
  ocm_stream_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_WORDS - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] wr_cnt_q;
  logic              rd_en_q;
  logic              start_low_q;
  logic              dp_vld;
  logic              wr_stb;
  logic              accept;

  // start_low_q resets to 0 so a level already high out of reset is not an edge
  assign accept = (state_q == IDLE) && start && start_low_q;

  // frame FSM with read address and write counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wr_cnt_q    <= '0;
      rd_en_q     <= 1'b0;
      start_low_q <= 1'b0;
    end else begin
      start_low_q <= ~start;
      if (wr_stb) wr_cnt_q <= wr_cnt_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= READ;
            addr_q   <= '0;
            wr_cnt_q <= '0;
            rd_en_q  <= 1'b1;
          end
        end
        READ: begin
          if (addr_q == LAST) begin
            state_q <= DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            addr_q <= addr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (wr_stb && (wr_cnt_q == LAST)) state_q <= DONE;
        end
        DONE: begin
          if (!start) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  ocm_seq_delay #(.DEPTH(RD_LAT)) u_rd_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rd_en_q),
    .q_o   (dp_vld)
  );

  ocm_seq_delay #(.DEPTH(PIPE_LAT)) u_pipe_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (dp_vld),
    .q_o   (wr_stb)
  );

  assign busy     = (state_q == READ) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign wr_count = wr_cnt_q;

  assign bus.ocm0_addr     = addr_q;
  assign bus.ocm0_chip     = rd_en_q;
  assign bus.ocm0_clk_enab = rd_en_q;

  assign bus.dp_valid = dp_vld;
  assign bus.dp_data  = dp_vld ? bus.ocm0_readdata : '0;

  assign bus.ocm1_addr      = wr_cnt_q;
  assign bus.ocm1_chip      = wr_stb;
  assign bus.ocm1_clk_enab  = wr_stb;
  assign bus.ocm1_write     = wr_stb;
  assign bus.ocm1_writedata = wr_stb ? bus.dp_result : '0;

`ifdef OCM_SEQ_PERF_EN
  logic [31:0] cyc_q;

  // frame cycle counter: clear on accept, count while busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cyc_q <= '0;
    else if (accept) cyc_q <= '0;
    else if (busy)   cyc_q <= cyc_q + 32'd1;
  end

  assign cycle_count = cyc_q;
`endif

endmodule
